// File: rtl/ptr_register_if.sv
// rtl/ptr_register_if.sv - control bundle for ptr_register: load byte, strobes and active-low bus enables
interface ptr_register_if;
    logic [7:0] di;
    logic       n_oe_addr;
    logic       n_oe_dl;
    logic       n_oe_dh;
    logic       cnt;
    logic       n_we_l;
    logic       n_we_h;

    modport master (
        output di, n_oe_addr, n_oe_dl, n_oe_dh, cnt, n_we_l, n_we_h
    );

    modport slave (
        input  di, n_oe_addr, n_oe_dl, n_oe_dh, cnt, n_we_l, n_we_h
    );
endinterface

// File: rtl/ptr_register.sv
// rtl/ptr_register.sv - 16-bit byte-loadable, incrementing pointer register with tri-state bus outputs
// Optional terminal-count output tc is compiled in with PTR_TERMINAL_COUNT_EN.
module ptr_register #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    ptr_register_if.slave   bus,
    output tri   [15:0]     addr_out,
    output tri   [7:0]      data_out
`ifdef PTR_TERMINAL_COUNT_EN
    ,
    output logic            tc
`endif
);

    logic [15:0] r_ptr;
    logic        w_we_l;
    logic        w_we_h;
    logic        w_write;
    logic [7:0]  w_data_sel;
    logic        w_data_en;

    assign w_we_l  = ~bus.n_we_l;
    assign w_we_h  = ~bus.n_we_h;
    assign w_write = w_we_l | w_we_h;

    // A byte write suppresses counting for the whole word, even for the byte left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= RESET_VALUE;
        end else if (w_write) begin
            if (w_we_l) begin
                r_ptr[7:0] <= bus.di;
            end
            if (w_we_h) begin
                r_ptr[15:8] <= bus.di;
            end
        end else if (bus.cnt) begin
            r_ptr <= r_ptr + 16'd1;
        end
    end

    // Low byte takes precedence so one instance never fights itself on data_out.
    always_comb begin
        w_data_sel = r_ptr[7:0];
        w_data_en  = 1'b0;
        if (!bus.n_oe_dl) begin
            w_data_sel = r_ptr[7:0];
            w_data_en  = 1'b1;
        end else if (!bus.n_oe_dh) begin
            w_data_sel = r_ptr[15:8];
            w_data_en  = 1'b1;
        end
    end

    assign addr_out = (!bus.n_oe_addr) ? r_ptr : 16'hzzzz;
    assign data_out = w_data_en ? w_data_sel : 8'hzz;

`ifdef PTR_TERMINAL_COUNT_EN
    assign tc = (r_ptr == 16'hFFFF) & bus.cnt & bus.n_we_l & bus.n_we_h & ~rst;
`endif

endmodule

// File: tb/tb_ptr_register.sv
// tb/tb_ptr_register.sv - self-checking bench for ptr_register: directed scenarios plus randomized run against a reference model
module tb_ptr_register;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    tri   [15:0] addr_bus;
    tri   [7:0]  data_bus;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_a;
    logic [15:0] m_b;
`ifdef PTR_TERMINAL_COUNT_EN
    logic        tc_a;
    logic        tc_b;
`endif

    ptr_register_if ifa ();
    ptr_register_if ifb ();

    ptr_register #(.RESET_VALUE(16'h0000)) u_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifa.slave),
        .addr_out (addr_bus),
        .data_out (data_bus)
`ifdef PTR_TERMINAL_COUNT_EN
        ,
        .tc       (tc_a)
`endif
    );

    ptr_register #(.RESET_VALUE(16'h0000)) u_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifb.slave),
        .addr_out (addr_bus),
        .data_out (data_bus)
`ifdef PTR_TERMINAL_COUNT_EN
        ,
        .tc       (tc_b)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: pointer behaviour expressed as word-level arithmetic on the rules.
    function automatic logic [15:0] next_ptr(input logic [15:0] p, input logic r,
                                             input logic nwl, input logic nwh,
                                             input logic c, input logic [7:0] d);
        logic [7:0] lo;
        logic [7:0] hi;
        if (r) return 16'h0000;
        if (!nwl || !nwh) begin
            lo = nwl ? p[7:0]  : d;
            hi = nwh ? p[15:8] : d;
            return {hi, lo};
        end
        if (c) return 16'((int'(p) + 1) % 65536);
        return p;
    endfunction

    task automatic idle_all();
        ifa.di = 8'h00; ifa.n_oe_addr = 1'b1; ifa.n_oe_dl = 1'b1; ifa.n_oe_dh = 1'b1;
        ifa.cnt = 1'b0; ifa.n_we_l = 1'b1; ifa.n_we_h = 1'b1;
        ifb.di = 8'h00; ifb.n_oe_addr = 1'b1; ifb.n_oe_dl = 1'b1; ifb.n_oe_dh = 1'b1;
        ifb.cnt = 1'b0; ifb.n_we_l = 1'b1; ifb.n_we_h = 1'b1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        m_a = next_ptr(m_a, rst, ifa.n_we_l, ifa.n_we_h, ifa.cnt, ifa.di);
        m_b = next_ptr(m_b, rst, ifb.n_we_l, ifb.n_we_h, ifb.cnt, ifb.di);
        #1;
    endtask

    task automatic load_a(input logic [15:0] v);
        ifa.di = v[7:0];  ifa.n_we_l = 1'b0; tick(); ifa.n_we_l = 1'b1;
        ifa.di = v[15:8]; ifa.n_we_h = 1'b0; tick(); ifa.n_we_h = 1'b1;
    endtask

    task automatic load_b(input logic [15:0] v);
        ifb.di = v[7:0];  ifb.n_we_l = 1'b0; tick(); ifb.n_we_l = 1'b1;
        ifb.di = v[15:8]; ifb.n_we_h = 1'b0; tick(); ifb.n_we_h = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h0000) begin
            n_fail++; $display("FAIL reset_addr_a: got %h, required 0000", addr_bus);
        end
        ifa.n_oe_addr = 1'b1; ifb.n_oe_addr = 1'b0; ifb.n_oe_dh = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h0000 || data_bus !== 8'h00) begin
            n_fail++; $display("FAIL reset_b: got addr %h data %h, required 0000 00", addr_bus, data_bus);
        end
        idle_all();
    endtask

    task automatic test_byte_writes();
        ifa.di = 8'h34; ifa.n_we_l = 1'b0; tick(); ifa.n_we_l = 1'b1;
        ifa.di = 8'h12; ifa.n_we_h = 1'b0; tick(); ifa.n_we_h = 1'b1;
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h1234) begin
            n_fail++; $display("FAIL byte_addr: got %h, required 1234", addr_bus);
        end
        ifa.n_oe_addr = 1'b1; ifa.n_oe_dl = 1'b0; #1;
        n_tests++;
        if (data_bus !== 8'h34) begin
            n_fail++; $display("FAIL byte_low: got %h, required 34", data_bus);
        end
        ifa.n_oe_dl = 1'b1; ifa.n_oe_dh = 1'b0; #1;
        n_tests++;
        if (data_bus !== 8'h12) begin
            n_fail++; $display("FAIL byte_high: got %h, required 12", data_bus);
        end
        ifa.n_oe_dh = 1'b1; #1;
        n_tests++;
        if (addr_bus === 16'h1234 || data_bus === 8'h34 || data_bus === 8'h12) begin
            n_fail++; $display("FAIL released_bus: got addr %h data %h, required undriven", addr_bus, data_bus);
        end
        idle_all();
    endtask

    task automatic test_count_wrap();
        load_a(16'h00FF);
        ifa.cnt = 1'b1;
`ifdef PTR_TERMINAL_COUNT_EN
        #1;
        n_tests++;
        if (tc_a !== 1'b0) begin
            n_fail++; $display("FAIL tc_not_ffff: got %b, required 0", tc_a);
        end
`endif
        tick(); ifa.cnt = 1'b0;
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h0100) begin
            n_fail++; $display("FAIL carry: got %h, required 0100", addr_bus);
        end
        ifa.n_oe_addr = 1'b1;
        ifa.di = 8'hFF; ifa.n_we_l = 1'b0; ifa.n_we_h = 1'b0; tick();
        ifa.n_we_l = 1'b1; ifa.n_we_h = 1'b1;
`ifdef PTR_TERMINAL_COUNT_EN
        #1;
        n_tests++;
        if (tc_a !== 1'b0) begin
            n_fail++; $display("FAIL tc_no_cnt: got %b, required 0", tc_a);
        end
        ifa.cnt = 1'b1; #1;
        n_tests++;
        if (tc_a !== 1'b1) begin
            n_fail++; $display("FAIL tc_active: got %b, required 1", tc_a);
        end
`endif
        ifa.cnt = 1'b1;
        tick(); ifa.cnt = 1'b0;
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h0000) begin
            n_fail++; $display("FAIL wrap: got %h, required 0000", addr_bus);
        end
        idle_all();
    endtask

    task automatic test_priority();
        load_a(16'h1234);
        ifa.cnt = 1'b1; ifa.n_we_l = 1'b0; ifa.di = 8'hAA; tick(); idle_all();
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h12AA) begin
            n_fail++; $display("FAIL write_over_count: got %h, required 12AA", addr_bus);
        end
        ifa.n_oe_addr = 1'b1;
        ifa.di = 8'h5A; ifa.n_we_l = 1'b0; ifa.n_we_h = 1'b0; ifa.cnt = 1'b1; tick(); idle_all();
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h5A5A) begin
            n_fail++; $display("FAIL both_bytes: got %h, required 5A5A", addr_bus);
        end
        ifa.n_oe_addr = 1'b1;
        rst = 1'b1; ifa.di = 8'h77; ifa.n_we_l = 1'b0; ifa.n_we_h = 1'b0; ifa.cnt = 1'b1; tick(); idle_all();
        ifa.n_oe_addr = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h0000) begin
            n_fail++; $display("FAIL reset_wins: got %h, required 0000", addr_bus);
        end
        idle_all();
    endtask

    task automatic test_bus_sharing();
        load_a(16'h1234);
        load_b(16'hBEEF);
        ifa.n_oe_addr = 1'b0; ifb.n_oe_dl = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'h1234 || data_bus !== 8'hEF) begin
            n_fail++; $display("FAIL share_1: got addr %h data %h, required 1234 EF", addr_bus, data_bus);
        end
        idle_all();
        ifb.n_oe_addr = 1'b0; ifa.n_oe_dh = 1'b0; #1;
        n_tests++;
        if (addr_bus !== 16'hBEEF || data_bus !== 8'h12) begin
            n_fail++; $display("FAIL share_2: got addr %h data %h, required BEEF 12", addr_bus, data_bus);
        end
        idle_all();
        ifa.n_oe_dl = 1'b0; ifa.n_oe_dh = 1'b0; #1;
        n_tests++;
        if (data_bus !== 8'h34) begin
            n_fail++; $display("FAIL both_data_en: got %h, required 34", data_bus);
        end
        idle_all();
    endtask

    task automatic test_hold();
        load_b(16'hBEEF);
        ifb.n_oe_addr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (addr_bus !== 16'hBEEF) begin
                n_fail++; $display("FAIL hold_%0d: got %h, required BEEF", i, addr_bus);
            end
        end
        ifb.n_oe_addr = 1'b1; ifb.n_oe_dh = 1'b0; #1;
        n_tests++;
        if (data_bus !== 8'hBE) begin
            n_fail++; $display("FAIL hold_dh: got %h, required BE", data_bus);
        end
        ifb.n_oe_dh = 1'b1; ifb.n_oe_dl = 1'b0; #1;
        n_tests++;
        if (data_bus !== 8'hEF) begin
            n_fail++; $display("FAIL hold_dl: got %h, required EF", data_bus);
        end
        idle_all();
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 15) == 0);
            ifa.di        = 8'($urandom);
            ifa.cnt       = 1'($urandom);
            ifa.n_we_l    = ($urandom_range(0, 3) != 0);
            ifa.n_we_h    = ($urandom_range(0, 3) != 0);
            ifa.n_oe_addr = 1'($urandom);
            ifa.n_oe_dl   = 1'($urandom);
            ifa.n_oe_dh   = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ifa.n_we_l = 1'b0; ifa.di = 8'hFF;
                ifa.n_we_h = 1'b0;
            end
            #1;
            if (!ifa.n_oe_addr) begin
                n_tests++;
                if (addr_bus !== m_a) begin
                    n_fail++; $display("FAIL rand_addr_%0d: got %h, required %h", i, addr_bus, m_a);
                end
            end
            if (!ifa.n_oe_dl || !ifa.n_oe_dh) begin
                exp_d = (!ifa.n_oe_dl) ? m_a[7:0] : m_a[15:8];
                n_tests++;
                if (data_bus !== exp_d) begin
                    n_fail++; $display("FAIL rand_data_%0d: got %h, required %h", i, data_bus, exp_d);
                end
            end
`ifdef PTR_TERMINAL_COUNT_EN
            n_tests++;
            if (tc_a !== ((m_a == 16'hFFFF) && ifa.cnt && ifa.n_we_l && ifa.n_we_h && !rst)) begin
                n_fail++; $display("FAIL rand_tc_%0d: got %b, ptr %h", i, tc_a, m_a);
            end
`endif
            tick();
        end
        idle_all();
    endtask

    initial begin
        m_a = 16'hxxxx;
        m_b = 16'hxxxx;
        idle_all();
        @(negedge clk);
        test_reset();
        test_byte_writes();
        test_count_wrap();
        test_priority();
        test_bus_sharing();
        test_hold();
        rst = 1'b1; tick(); rst = 1'b0;
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
